multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_pkg.sv | 54 +++++
 rtl/multicycle_alu_muldiv_iter.sv | 106 ++++++++++
 rtl/multicycle_alu.sv | 157 +++++++++++++++
 tb/tb_multicycle_alu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared opcode header for the ALU family: 4-bit legacy codes zero-extended
// to 5 bits, plus the iterative multiply/divide codes.
package multicycle_alu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB   = 5'd1;
    localparam logic [OPC_W-1:0] OP_SLL   = 5'd2;
    localparam logic [OPC_W-1:0] OP_SLT   = 5'd3;
    localparam logic [OPC_W-1:0] OP_SLTU  = 5'd4;
    localparam logic [OPC_W-1:0] OP_XOR   = 5'd5;
    localparam logic [OPC_W-1:0] OP_SRL   = 5'd6;
    localparam logic [OPC_W-1:0] OP_SRA   = 5'd7;
    localparam logic [OPC_W-1:0] OP_OR    = 5'd8;
    localparam logic [OPC_W-1:0] OP_AND   = 5'd9;
    localparam logic [OPC_W-1:0] OP_BEQ   = 5'd10;
    localparam logic [OPC_W-1:0] OP_BNE   = 5'd11;
    localparam logic [OPC_W-1:0] OP_BLT   = 5'd12;
    localparam logic [OPC_W-1:0] OP_BGE   = 5'd13;
    localparam logic [OPC_W-1:0] OP_BLTU  = 5'd14;
    localparam logic [OPC_W-1:0] OP_BGEU  = 5'd15;
    localparam logic [OPC_W-1:0] OP_MUL   = 5'd16;
    localparam logic [OPC_W-1:0] OP_MULH  = 5'd17;
    localparam logic [OPC_W-1:0] OP_MULHU = 5'd18;
    localparam logic [OPC_W-1:0] OP_DIV   = 5'd19;
    localparam logic [OPC_W-1:0] OP_DIVU  = 5'd20;
    localparam logic [OPC_W-1:0] OP_REM   = 5'd21;
    localparam logic [OPC_W-1:0] OP_REMU  = 5'd22;

    // sel_hi selects the high product half for multiplies, the remainder for divides
    typedef struct packed {
        logic is_div;
        logic sel_hi;
        logic sgn_a;
        logic sgn_b;
    } md_cfg_t;

    function automatic md_cfg_t md_cfg(input logic [31:0] op);
        md_cfg_t c;
        c = '0;
        case (op)
            32'(OP_MULH):  c = '{is_div: 1'b0, sel_hi: 1'b1, sgn_a: 1'b1, sgn_b: 1'b1};
            32'(OP_MULHU): c = '{is_div: 1'b0, sel_hi: 1'b1, sgn_a: 1'b0, sgn_b: 1'b0};
            32'(OP_DIV):   c = '{is_div: 1'b1, sel_hi: 1'b0, sgn_a: 1'b1, sgn_b: 1'b1};
            32'(OP_DIVU):  c = '{is_div: 1'b1, sel_hi: 1'b0, sgn_a: 1'b0, sgn_b: 1'b0};
            32'(OP_REM):   c = '{is_div: 1'b1, sel_hi: 1'b1, sgn_a: 1'b1, sgn_b: 1'b1};
            32'(OP_REMU):  c = '{is_div: 1'b1, sel_hi: 1'b1, sgn_a: 1'b0, sgn_b: 1'b0};
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// one step per cycle for XLEN cycles, with sign fixup on the final step.
module muldiv_iter
    import multicycle_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  md_cfg_t         cfg,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic            run_q, run_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic            is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d;

    logic            sa, sb;
    logic [XLEN:0]   sum, shl;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] qv, rv;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        neg_d    = neg_q;
        done     = 1'b0;
        sa       = cfg.sgn_a & op_a[XLEN-1];
        sb       = cfg.sgn_b & op_b[XLEN-1];
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shl      = {hi_q, lo_q[XLEN-1]};

        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = sa ? -op_a : op_a;
            m_d      = sb ? -op_b : op_b;
            is_div_d = cfg.is_div;
            sel_hi_d = cfg.sel_hi;
            // remainder follows the dividend sign; quotient/product the xor of signs
            neg_d    = (cfg.is_div && cfg.sel_hi) ? sa : (sa ^ sb);
        end else if (run_q) begin
            if (is_div_q) begin
                if (shl >= {1'b0, m_q}) begin
                    hi_d = XLEN'(shl - {1'b0, m_q});
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = shl[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
                done  = 1'b1;
                run_d = 1'b0;
                cnt_d = '0;
            end
        end

        prod   = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        qv     = neg_q ? -lo_d : lo_d;
        rv     = neg_q ? -hi_d : hi_d;
        result = is_div_q ? (sel_hi_q ? rv : qv)
                          : (sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-step ops finish in one cycle, multiply/divide iterate
// XLEN cycles in muldiv_iter; results are registered and held between pulses.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] alu_op,
    input  logic [XLEN-1:0] alu_in_1,
    input  logic [XLEN-1:0] alu_in_2,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_bcond,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            bcond_q, bcond_d;

    logic [31:0]     op_x;
    logic [SHW-1:0]  sh;
    logic            accept, iter, div_zero, div_ovf, md_start, md_done;
    logic [XLEN-1:0] ss_res, md_result;
    logic            ss_bc;

    assign op_x     = 32'(alu_op);
    assign sh       = alu_in_2[SHW-1:0];
    assign accept   = in_valid && in_ready && !flush;
    assign div_zero = (alu_in_2 == '0);
    assign div_ovf  = (alu_in_1 == MOST_NEG) && (alu_in_2 == '1);

    // Divide corner cases resolve here so they never enter the iterative path.
    always_comb begin
        ss_res = '0;
        ss_bc  = 1'b0;
        iter   = 1'b0;
        case (op_x)
            32'(OP_ADD):  ss_res = alu_in_1 + alu_in_2;
            32'(OP_SUB):  ss_res = alu_in_1 - alu_in_2;
            32'(OP_SLL):  ss_res = alu_in_1 << sh;
            32'(OP_SRL):  ss_res = alu_in_1 >> sh;
            32'(OP_SRA):  ss_res = $unsigned($signed(alu_in_1) >>> sh);
            32'(OP_XOR):  ss_res = alu_in_1 ^ alu_in_2;
            32'(OP_OR):   ss_res = alu_in_1 | alu_in_2;
            32'(OP_AND):  ss_res = alu_in_1 & alu_in_2;
            32'(OP_SLT):  ss_res = {{(XLEN-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
            32'(OP_SLTU): ss_res = {{(XLEN-1){1'b0}}, alu_in_1 < alu_in_2};
            32'(OP_BEQ):  ss_bc  = (alu_in_1 == alu_in_2);
            32'(OP_BNE):  ss_bc  = (alu_in_1 != alu_in_2);
            32'(OP_BLT):  ss_bc  = ($signed(alu_in_1) < $signed(alu_in_2));
            32'(OP_BGE):  ss_bc  = ($signed(alu_in_1) >= $signed(alu_in_2));
            32'(OP_BLTU): ss_bc  = (alu_in_1 < alu_in_2);
            32'(OP_BGEU): ss_bc  = (alu_in_1 >= alu_in_2);
            32'(OP_MUL), 32'(OP_MULH), 32'(OP_MULHU): iter = 1'b1;
            32'(OP_DIV): begin
                if (div_zero)     ss_res = '1;
                else if (div_ovf) ss_res = alu_in_1;
                else              iter   = 1'b1;
            end
            32'(OP_DIVU): begin
                if (div_zero) ss_res = '1;
                else          iter   = 1'b1;
            end
            32'(OP_REM): begin
                if (div_zero)     ss_res = alu_in_1;
                else if (div_ovf) ss_res = '0;
                else              iter   = 1'b1;
            end
            32'(OP_REMU): begin
                if (div_zero) ss_res = alu_in_1;
                else          iter   = 1'b1;
            end
            default: begin
                ss_res = '0;
                ss_bc  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        bcond_d  = bcond_q;
        md_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (iter) begin
                        state_d  = S_CALC;
                        md_start = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        result_d = ss_res;
                        bcond_d  = ss_bc;
                    end
                end
            end
            S_CALC: begin
                if (md_done) begin
                    state_d  = S_DONE;
                    result_d = md_result;
                    bcond_d  = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            bcond_d  = bcond_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            bcond_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            bcond_q  <= bcond_d;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (md_start),
        .cfg    (md_cfg(op_x)),
        .op_a   (alu_in_1),
        .op_b   (alu_in_2),
        .done   (md_done),
        .result (md_result)
    );

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign alu_result = result_q;
    assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed vector bench for multicycle_alu: 32-bit and 8-bit instances,
// plus hand-written flush and reset-abort sequences.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;

    logic        iv32, rdy32, ov32, bc32, busy32;
    logic [4:0]  op32;
    logic [31:0] a32, b32, r32;

    logic        iv8, rdy8, ov8, bc8, busy8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, r8;

    multicycle_alu dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32), .alu_op(op32),
        .alu_in_1(a32), .alu_in_2(b32), .flush(flush), .out_valid(ov32),
        .alu_result(r32), .alu_bcond(bc32), .busy(busy32)
    );

    multicycle_alu #(.XLEN(8), .OP_W(5)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(rdy8), .alu_op(op8),
        .alu_in_1(a8), .alu_in_2(b8), .flush(flush), .out_valid(ov8),
        .alu_result(r8), .alu_bcond(bc8), .busy(busy8)
    );

    logic        sel8;
    logic        m_ov, m_busy, m_bc, m_rdy;
    logic [31:0] m_res;
    assign m_ov   = sel8 ? ov8   : ov32;
    assign m_busy = sel8 ? busy8 : busy32;
    assign m_bc   = sel8 ? bc8   : bc32;
    assign m_rdy  = sel8 ? rdy8  : rdy32;
    assign m_res  = sel8 ? {24'h0, r8} : r32;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic s8, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic bc, output int lat,
                          output logic busy_ok, output logic pulse_ok);
        sel8 = s8;
        @(negedge clk);
        if (s8) begin
            iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            iv32 = 1'b1; op32 = op; a32 = a; b32 = b;
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        iv32 = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (1) begin
            if (!m_busy) busy_ok = 1'b0;
            if (m_ov || lat >= 100) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!m_ov) lat = -1;
        res = m_res;
        bc  = m_bc;
        @(posedge clk);
        #1;
        pulse_ok = !m_ov && m_rdy && (m_res === res);
    endtask

    typedef struct {
        logic        s8;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
        int          lat;
    } vec_t;

    vec_t v[$];

    task automatic run_table(input logic want8);
        logic [31:0] res;
        logic bc, busy_ok, pulse_ok;
        int lat;
        for (int i = 0; i < v.size(); i++) begin
            if (v[i].s8 != want8) continue;
            run_op(v[i].s8, v[i].op, v[i].a, v[i].b, res, bc, lat, busy_ok, pulse_ok);
            chk($sformatf("v%0d op%0d result", i, v[i].op), res, v[i].res);
            chk($sformatf("v%0d op%0d bcond", i, v[i].op), {31'h0, bc}, {31'h0, v[i].bc});
            chk($sformatf("v%0d op%0d latency", i, v[i].op), lat, v[i].lat);
            chk($sformatf("v%0d op%0d busy", i, v[i].op), {31'h0, busy_ok}, 32'h1);
            chk($sformatf("v%0d op%0d pulse_end", i, v[i].op), {31'h0, pulse_ok}, 32'h1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] res, held;
        logic bc, busy_ok, pulse_ok, saw_ov;
        int lat;

        reset = 1'b1; flush = 1'b0; sel8 = 1'b0;
        iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        iv8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;

        // 32-bit vectors
        v.push_back('{1'b0, OP_ADD,   32'd7,         32'd5,         32'd12,        1'b0, 1});
        v.push_back('{1'b0, OP_SUB,   32'd5,         32'd7,         32'hFFFFFFFE,  1'b0, 1});
        v.push_back('{1'b0, OP_ADD,   32'hFFFFFFFF,  32'd1,         32'h0,         1'b0, 1});
        v.push_back('{1'b0, OP_SLL,   32'd1,         32'd31,        32'h80000000,  1'b0, 1});
        v.push_back('{1'b0, OP_SLL,   32'd1,         32'h23,        32'h8,         1'b0, 1});
        v.push_back('{1'b0, OP_SRA,   32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1});
        v.push_back('{1'b0, OP_SRL,   32'h80000000,  32'd4,         32'h08000000,  1'b0, 1});
        v.push_back('{1'b0, OP_XOR,   32'hF0F0,      32'hFF00,      32'h0FF0,      1'b0, 1});
        v.push_back('{1'b0, OP_OR,    32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 1});
        v.push_back('{1'b0, OP_AND,   32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1});
        v.push_back('{1'b0, OP_SLT,   32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1});
        v.push_back('{1'b0, OP_SLTU,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1});
        v.push_back('{1'b0, OP_BEQ,   32'd5,         32'd5,         32'd0,         1'b1, 1});
        v.push_back('{1'b0, OP_BNE,   32'd5,         32'd5,         32'd0,         1'b0, 1});
        v.push_back('{1'b0, OP_BLT,   32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1});
        v.push_back('{1'b0, OP_BLTU,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1});
        v.push_back('{1'b0, OP_BGE,   32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1});
        v.push_back('{1'b0, OP_BGEU,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1});
        v.push_back('{1'b0, OP_MUL,   32'd6,         32'd7,         32'd42,        1'b0, 33});
        v.push_back('{1'b0, OP_MUL,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         1'b0, 33});
        v.push_back('{1'b0, OP_MULH,  32'h80000000,  32'h80000000,  32'h40000000,  1'b0, 33});
        v.push_back('{1'b0, OP_MULH,  32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, 33});
        v.push_back('{1'b0, OP_MULHU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 33});
        v.push_back('{1'b0, OP_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 33});
        v.push_back('{1'b0, OP_REM,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, 33});
        v.push_back('{1'b0, OP_DIV,   32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0, 33});
        v.push_back('{1'b0, OP_REM,   32'd7,         32'hFFFFFFFE,  32'd1,         1'b0, 33});
        v.push_back('{1'b0, OP_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 33});
        v.push_back('{1'b0, OP_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 33});
        v.push_back('{1'b0, OP_DIVU,  32'd5,         32'd0,         32'hFFFFFFFF,  1'b0, 1});
        v.push_back('{1'b0, OP_REMU,  32'd5,         32'd0,         32'd5,         1'b0, 1});
        v.push_back('{1'b0, OP_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 1});
        v.push_back('{1'b0, OP_REM,   32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, 1});
        v.push_back('{1'b0, 5'd31,    32'd3,         32'd4,         32'd0,         1'b0, 1});
        // 8-bit vectors
        v.push_back('{1'b1, OP_ADD,   32'd7,         32'd5,         32'd12,        1'b0, 1});
        v.push_back('{1'b1, OP_DIV,   32'hF9,        32'd2,         32'hFD,        1'b0, 9});
        v.push_back('{1'b1, OP_REM,   32'hF9,        32'd2,         32'hFF,        1'b0, 9});
        v.push_back('{1'b1, OP_DIVU,  32'd5,         32'd0,         32'hFF,        1'b0, 1});
        v.push_back('{1'b1, OP_DIV,   32'h80,        32'hFF,        32'h80,        1'b0, 1});
        v.push_back('{1'b1, OP_REM,   32'h80,        32'hFF,        32'h00,        1'b0, 1});
        v.push_back('{1'b1, OP_MULH,  32'h80,        32'h80,        32'h40,        1'b0, 9});
        v.push_back('{1'b1, OP_BLT,   32'hFF,        32'd1,         32'd0,         1'b1, 1});
        v.push_back('{1'b1, OP_SLL,   32'd1,         32'h0A,        32'd4,         1'b0, 1});

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset out_valid", {31'h0, ov32}, 32'h0);
        chk("reset busy",      {31'h0, busy32}, 32'h0);
        chk("reset in_ready",  {31'h0, rdy32}, 32'h1);
        chk("reset result",    r32, 32'h0);
        chk("reset bcond",     {31'h0, bc32}, 32'h0);
        chk("reset8 in_ready", {31'h0, rdy8}, 32'h1);

        run_table(1'b0);

        // flush during the 10th CALC cycle of a DIV
        sel8 = 1'b0;
        held = r32;
        @(negedge clk);
        iv32 = 1'b1; op32 = OP_DIV; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush in_ready", {31'h0, rdy32}, 32'h1);
        chk("flush out_valid", {31'h0, ov32}, 32'h0);
        chk("flush busy", {31'h0, busy32}, 32'h0);
        saw_ov = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov32) saw_ov = 1'b1;
        end
        chk("flush no out_valid", {31'h0, saw_ov}, 32'h0);
        chk("flush result held", r32, held);
        run_op(1'b0, OP_ADD, 32'd7, 32'd5, res, bc, lat, busy_ok, pulse_ok);
        chk("post-flush add result", res, 32'd12);
        chk("post-flush add latency", lat, 1);

        // reset in the middle of a MUL
        @(negedge clk);
        iv32 = 1'b1; op32 = OP_MUL; a32 = 32'h1234; b32 = 32'h10;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        chk("midreset out_valid", {31'h0, ov32}, 32'h0);
        chk("midreset busy", {31'h0, busy32}, 32'h0);
        chk("midreset in_ready", {31'h0, rdy32}, 32'h1);
        chk("midreset result", r32, 32'h0);
        chk("midreset bcond", {31'h0, bc32}, 32'h0);
        saw_ov = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov32) saw_ov = 1'b1;
        end
        chk("midreset no out_valid", {31'h0, saw_ov}, 32'h0);

        run_table(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
